// File: rtl/inst_fetch_pkg.sv
// Shared core constants for the fetch stage: FSM encoding, parameter defaults,
// the canonical NOP and the FIFO entry layout.
package inst_fetch_pkg;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_HALT_INST = 32'h0000_0000;
  localparam logic [31:0] NOP_INST      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Word-align a fetch address; the low two bits are never issued.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Two-entry {pc,inst} queue between the fetch response and decode, with a
// single-cycle flush used on redirect.
module fetch_fifo
  import inst_fetch_pkg::*;
(
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [31:0] push_pc_i,
  input  logic [31:0] push_inst_i,
  input  logic        pop_i,
  output logic [31:0] head_pc_o,
  output logic [31:0] head_inst_o,
  output logic [1:0]  count_o
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= '{pc: push_pc_i, inst: push_inst_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_pc_o   = mem_q[rd_ptr_q].pc;
  assign head_inst_o = mem_q[rd_ptr_q].inst;
  assign count_o     = count_q;

  // The issue rule bounds queued + in-flight to two, so this must never fire.
  a_no_overflow: assert property (@(posedge clk_50) disable iff (!rst_n)
    !(push_i && !flush_i && (count_q == 2'd2) && !pop_i));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding request to a 1-cycle-latency memory,
// a 2-entry decode queue, redirect/flush, and halt on a designated instruction word.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] HALT_INST = DEF_HALT_INST
) (
  input  logic        clk_50,
  input  logic        rst_n,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_INST,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        halted
);

  logic [1:0]  state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic [1:0]  count;
  logic [1:0]  occupancy;
  logic        pop;
  logic        capture;
  logic        halt_hit;
  logic        push;
  logic        issue;

  assign pop       = if_valid && if_ready;
  assign capture   = inflight_q && !redirect_valid;
  assign halt_hit  = capture && (IMEM_INST == HALT_INST);
  assign push      = capture && !halt_hit;
  assign occupancy = count + {1'b0, inflight_q};
  // Keep queued + in-flight at most two so a response always has a slot.
  assign issue     = (state_q == ST_RUN) && !redirect_valid && !halt_hit &&
                     ((occupancy <= 2'd1) || ((occupancy == 2'd2) && pop));

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    if (redirect_valid) begin
      state_d = ST_RUN;
      fpc_d   = align_pc(redirect_pc);
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN:  if (halt_hit) state_d = ST_HALT;
        default: state_d = state_q;
      endcase
      if (issue) begin
        fpc_d = fpc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      fpc_q         <= align_pc(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= fpc_q;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk_50      (clk_50),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_pc_i   (inflight_pc_q),
    .push_inst_i (IMEM_INST),
    .pop_i       (pop),
    .head_pc_o   (if_pc),
    .head_inst_o (if_inst),
    .count_o     (count)
  );

  assign IMEM_ADDR = fpc_q;
  assign if_valid  = (count != 2'd0);
  assign halted    = (state_q == ST_HALT);

endmodule
